// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the lab-board ALU. It debounces the next/clear buttons,
// loads A, B and opcode/carry-in from the switches, and captures the ALU result.
module alu_operand_sequencer #(
    parameter int W        = 3,
    parameter int DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] sw,
    input  logic         sw_cin,
    input  logic         btn_next,
    input  logic         btn_clr,
    input  logic [W-1:0] alu_y,
    input  logic         alu_c_out,
    input  logic         alu_v,
    input  logic         alu_n,
    input  logic         alu_z,
    output logic [W-1:0] opcode,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         c_in,
    output logic [W-1:0] result,
    output logic [3:0]   flags,
    output logic         result_valid,
    output logic [2:0]   state
);
    localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

    localparam logic [2:0] LOAD_A  = 3'd0;
    localparam logic [2:0] LOAD_B  = 3'd1;
    localparam logic [2:0] LOAD_OP = 3'd2;
    localparam logic [2:0] EXEC    = 3'd3;
    localparam logic [2:0] SHOW    = 3'd4;

    // Index 0 is the next button, index 1 the clear button.
    logic [1:0]         raw;
    logic [1:0]         sync1_q, sync2_q, lvl_q, lvl_prev_q;
    logic [1:0][CW-1:0] cnt_q;
    logic               next_p, clr_p;

    assign raw = {btn_clr, btn_next};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            lvl_prev_q <= lvl_q;
            for (int i = 0; i < 2; i++) begin
                // Level flips only after DEBOUNCE consecutive disagreeing samples.
                if (sync2_q[i] != lvl_q[i]) begin
                    if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
                        lvl_q[i] <= ~lvl_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign next_p = lvl_q[0] & ~lvl_prev_q[0];
    assign clr_p  = lvl_q[1] & ~lvl_prev_q[1];

    logic [2:0]   state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, op_q, op_d, res_q, res_d;
    logic         cin_q, cin_d, rv_q, rv_d;
    logic [3:0]   flags_q, flags_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cin_d   = cin_q;
        res_d   = res_q;
        flags_d = flags_q;
        rv_d    = rv_q;
        if (clr_p) begin
            state_d = LOAD_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            cin_d   = 1'b0;
            res_d   = '0;
            flags_d = '0;
            rv_d    = 1'b0;
        end else begin
            case (state_q)
                LOAD_A:  if (next_p) begin a_d = sw; state_d = LOAD_B; end
                LOAD_B:  if (next_p) begin b_d = sw; state_d = LOAD_OP; end
                LOAD_OP: if (next_p) begin
                    op_d    = sw;
                    cin_d   = sw_cin;
                    state_d = EXEC;
                end
                EXEC: begin
                    res_d   = alu_y;
                    flags_d = {alu_c_out, alu_v, alu_n, alu_z};
                    rv_d    = 1'b1;
                    state_d = SHOW;
                end
                SHOW:    if (next_p) begin rv_d = 1'b0; state_d = LOAD_A; end
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cin_q   <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cin_q   <= cin_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            rv_q    <= rv_d;
        end
    end

    assign opcode       = op_q;
    assign a            = a_q;
    assign b            = b_q;
    assign c_in         = cin_q;
    assign result       = res_q;
    assign flags        = flags_q;
    assign result_valid = rv_q;
    assign state        = state_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small shift-ALU model.
module tb_alu_operand_sequencer;
    localparam int W = 3;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] sw = '0;
    logic         sw_cin = 1'b0;
    logic         btn_next = 1'b0;
    logic         btn_clr = 1'b0;
    logic [W-1:0] alu_y;
    logic         alu_c_out = 1'b0, alu_v = 1'b0, alu_n = 1'b0, alu_z = 1'b0;
    logic [W-1:0] opcode, a, b, result;
    logic         c_in, result_valid;
    logic [3:0]   flags;
    logic [2:0]   state;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    alu_operand_sequencer #(.W(W), .DEBOUNCE(D)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .sw_cin(sw_cin),
        .btn_next(btn_next), .btn_clr(btn_clr), .alu_y(alu_y),
        .alu_c_out(alu_c_out), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
        .opcode(opcode), .a(a), .b(b), .c_in(c_in), .result(result),
        .flags(flags), .result_valid(result_valid), .state(state)
    );

    always #5 clk = ~clk;

    // Opcode 0 shifts left, anything else shifts right.
    always_comb begin
        if (opcode == '0) alu_y = W'(a << b);
        else              alu_y = W'(a >> b);
    end

    // Raise the chosen buttons and wait (bounded) for the state to move.
    task automatic hold_btns(input logic nxt, input logic clr,
                             output logic [2:0] seen, output bit ok);
        logic [2:0] s0;
        s0 = state;
        btn_next = nxt;
        btn_clr = clr;
        ok = 1'b0;
        seen = s0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state !== s0) begin
                seen = state;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_btns();
        btn_next = 1'b0;
        btn_clr = 1'b0;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic step_next(input logic [W-1:0] v, input logic [2:0] exp_st, input string nm);
        logic [2:0] seen;
        bit ok;
        sw = v;
        hold_btns(1'b1, 1'b0, seen, ok);
        tot_cnt++;
        if (!ok || seen !== exp_st)
            $display("FAIL %s: state %0d ok %0d, expected %0d", nm, seen, ok, exp_st);
        else pass_cnt++;
        release_btns();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tot_cnt++;
        if ({opcode, a, b, c_in, result, flags, result_valid, state} !== '0)
            $display("FAIL reset_outputs: got %h, expected 0",
                     {opcode, a, b, c_in, result, flags, result_valid, state});
        else pass_cnt++;
    endtask

    task automatic test_debounce();
        logic [2:0] seen;
        bit ok;
        for (int i = 0; i < 10; i++) begin
            btn_next = ~btn_next;
            repeat (2) @(negedge clk);
        end
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        tot_cnt++;
        if (state !== 3'd0) $display("FAIL bounce_ignored: state %0d, expected 0", state);
        else pass_cnt++;

        sw = 3'd3;
        btn_next = 1'b1;
        repeat (D + 2) @(posedge clk);
        @(negedge clk);
        tot_cnt++;
        if (state !== 3'd0) $display("FAIL press_too_early: state %0d, expected 0", state);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        tot_cnt++;
        if (state !== 3'd1) $display("FAIL press_latency: state %0d, expected 1", state);
        else pass_cnt++;
        repeat (50 - D - 3) @(negedge clk);
        tot_cnt++;
        if (state !== 3'd1 || a !== 3'd3)
            $display("FAIL held_single_pulse: state %0d a %0d, expected 1 and 3", state, a);
        else pass_cnt++;
        release_btns();
        tot_cnt++;
        if (state !== 3'd1) $display("FAIL release_no_pulse: state %0d, expected 1", state);
        else pass_cnt++;
        hold_btns(1'b0, 1'b1, seen, ok);
        release_btns();
    endtask

    task automatic test_basic_shift();
        logic [2:0] seen;
        bit ok;
        step_next(3'd3, 3'd1, "shl_load_a");
        step_next(3'd1, 3'd2, "shl_load_b");
        tot_cnt++;
        if (a !== 3'd3 || b !== 3'd1) $display("FAIL shl_operands: a %0d b %0d, expected 3 1", a, b);
        else pass_cnt++;
        sw = 3'd0;
        sw_cin = 1'b0;
        hold_btns(1'b1, 1'b0, seen, ok);
        tot_cnt++;
        if (!ok || seen !== 3'd3 || result_valid !== 1'b0 || opcode !== 3'd0)
            $display("FAIL shl_exec: state %0d rv %0d op %0d, expected 3 0 0", seen, result_valid, opcode);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if (state !== 3'd4 || result !== 3'd6 || result_valid !== 1'b1)
            $display("FAIL shl_show: state %0d result %0d rv %0d, expected 4 6 1", state, result, result_valid);
        else pass_cnt++;
        release_btns();
    endtask

    task automatic test_shr_flags();
        logic [2:0] seen;
        bit ok;
        step_next(3'd0, 3'd0, "show_ack");
        tot_cnt++;
        if (result_valid !== 1'b0 || result !== 3'd6)
            $display("FAIL ack_rv_low: rv %0d result %0d, expected 0 6", result_valid, result);
        else pass_cnt++;
        step_next(3'd5, 3'd1, "shr_load_a");
        step_next(3'd1, 3'd2, "shr_load_b");
        {alu_c_out, alu_v, alu_n, alu_z} = 4'b1010;
        sw = 3'd1;
        sw_cin = 1'b1;
        hold_btns(1'b1, 1'b0, seen, ok);
        tot_cnt++;
        if (!ok || seen !== 3'd3 || c_in !== 1'b1)
            $display("FAIL shr_exec: state %0d cin %0d, expected 3 1", seen, c_in);
        else pass_cnt++;
        @(negedge clk);
        {alu_c_out, alu_v, alu_n, alu_z} = 4'b0101;
        tot_cnt++;
        if (result !== 3'd2 || flags !== 4'b1010)
            $display("FAIL shr_capture: result %0d flags %b, expected 2 1010", result, flags);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        tot_cnt++;
        if (flags !== 4'b1010 || state !== 3'd4)
            $display("FAIL shr_hold: flags %b state %0d, expected 1010 4", flags, state);
        else pass_cnt++;
        {alu_c_out, alu_v, alu_n, alu_z} = 4'b0000;
        release_btns();
    endtask

    task automatic test_clear();
        logic [2:0] seen;
        bit ok;
        step_next(3'd0, 3'd0, "clr_ack");
        step_next(3'd3, 3'd1, "clr_load_a");
        step_next(3'd1, 3'd2, "clr_load_b");
        hold_btns(1'b0, 1'b1, seen, ok);
        tot_cnt++;
        if (!ok || {opcode, a, b, c_in, result, flags, result_valid, state} !== '0)
            $display("FAIL clear_all: ok %0d got %h, expected 0", ok,
                     {opcode, a, b, c_in, result, flags, result_valid, state});
        else pass_cnt++;
        release_btns();
    endtask

    task automatic test_simultaneous();
        logic [2:0] seen;
        bit ok;
        step_next(3'd6, 3'd1, "sim_load_a");
        sw = 3'd5;
        hold_btns(1'b1, 1'b1, seen, ok);
        tot_cnt++;
        if (!ok || seen !== 3'd0 || a !== 3'd0 || b !== 3'd0)
            $display("FAIL clear_wins: state %0d a %0d b %0d, expected 0 0 0", seen, a, b);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        tot_cnt++;
        if (state !== 3'd0) $display("FAIL clear_wins_stay: state %0d, expected 0", state);
        else pass_cnt++;
        release_btns();
    endtask

    task automatic test_reset_mid();
        logic [2:0] seen;
        bit ok;
        step_next(3'd3, 3'd1, "rst_load_a");
        step_next(3'd1, 3'd2, "rst_load_b");
        sw = 3'd0;
        sw_cin = 1'b0;
        hold_btns(1'b1, 1'b0, seen, ok);
        release_btns();
        tot_cnt++;
        if (state !== 3'd4 || result !== 3'd6)
            $display("FAIL rst_setup: state %0d result %0d, expected 4 6", state, result);
        else pass_cnt++;
        sw = 3'd7;
        btn_next = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tot_cnt++;
        if ({opcode, a, b, c_in, result, flags, result_valid, state} !== '0)
            $display("FAIL rst_mid_outputs: got %h, expected 0",
                     {opcode, a, b, c_in, result, flags, result_valid, state});
        else pass_cnt++;
        repeat (D + 2) @(posedge clk);
        @(negedge clk);
        tot_cnt++;
        if (state !== 3'd0) $display("FAIL rst_held_early: state %0d, expected 0", state);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        tot_cnt++;
        if (state !== 3'd1 || a !== 3'd7)
            $display("FAIL rst_held_pulse: state %0d a %0d, expected 1 7", state, a);
        else pass_cnt++;
        release_btns();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_debounce();
        test_basic_shift();
        test_shr_flags();
        test_clear();
        test_simultaneous();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
